output_serializer: RTL and testbench



---
 rtl/output_serializer_pkg.sv | 59 +++++
 rtl/output_serializer_if.sv | 39 +++
 rtl/output_serializer_beat_select.sv | 43 ++++
 rtl/output_serializer.sv | 203 ++++++++++++++++++++
 tb/tb_output_serializer.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/output_serializer_pkg.sv
// -----------------------------------------------------------------------------
// output_serializer_pkg
// Shared definitions for the systolic-array result drain:
//   - FSM state encoding (IDLE / WAIT / TX)
//   - default geometry and the derived word/beat/frame sizes
//   - counter-width helper ($clog2 with a floor of one bit)
//   - element-order mapping (row-major or column-major/transposed)
// No ports; imported by every other file in this slice.
// -----------------------------------------------------------------------------
package output_serializer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_TX   = 2'd2
  } state_e;

  // Width of a counter that must hold values 0..v-1. Never narrower than one
  // bit, so degenerate sizes (v = 1 or 0) still give a legal vector.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  function automatic int word_width(input int d_w);
    return 2 * d_w;
  endfunction

  function automatic int beats_per_word(input int d_w, input int lanes);
    return word_width(d_w) / lanes;
  endfunction

  function automatic int frame_beats(input int d_w, input int n, input int lanes);
    return n * n * beats_per_word(d_w, lanes);
  endfunction

  // Sequence index j -> accumulator word k. Column-major emits the transpose:
  // j = r'*N + c' reads word c'*N + r'.
  function automatic int map_element(input int j, input int n, input logic col_major);
    int r;
    int c;
    if (!col_major) begin
      return j;
    end
    r = j / n;
    c = j % n;
    return c * n + r;
  endfunction

  // Default geometry, shared by the top-level and interface parameter lists.
  localparam int DEF_D_W        = 8;
  localparam int DEF_N          = 2;
  localparam int DEF_LANES      = 1;
  localparam int DEF_INIT_DELAY = 2;

  localparam int W     = word_width(DEF_D_W);
  localparam int BEATS = beats_per_word(DEF_D_W, DEF_LANES);
  localparam int FRAME = frame_beats(DEF_D_W, DEF_N, DEF_LANES);

endpackage

// File: rtl/output_serializer_if.sv
// -----------------------------------------------------------------------------
// output_serializer_if
// Valid/ready beat stream from the serializer to the output pins.
//   out_data  [LANES-1:0]  current beat
//   out_valid              beat valid
//   out_ready              sink accepts the beat
//   out_first              beat 0 of a frame
//   out_last               final beat of a frame
// Modports: master (serializer side), slave (sink side).
// -----------------------------------------------------------------------------
interface output_serializer_if
  import output_serializer_pkg::*;
#(
  parameter int LANES = DEF_LANES
);

  logic [LANES-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_first;
  logic             out_last;

  modport master (
    output out_data,
    output out_valid,
    output out_first,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_first,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/output_serializer_beat_select.sv
// -----------------------------------------------------------------------------
// output_serializer_beat_select
// Combinational slicer: picks one LANES-bit beat out of a W-bit word.
//   word_i       [W-1:0]       word being serialized
//   beat_i       [BEAT_W-1:0]  beat index within the word (0 = first sent)
//   msb_first_i                0: beat b = word[b*LANES +: LANES]
//                              1: beat b = word[W-1-b*LANES -: LANES]
//   beat_o       [LANES-1:0]   selected beat
// -----------------------------------------------------------------------------
module output_serializer_beat_select #(
  parameter int W      = 16,
  parameter int LANES  = 1,
  parameter int BEATS  = W / LANES,
  parameter int BEAT_W = 4
) (
  input  logic [W-1:0]      word_i,
  input  logic [BEAT_W-1:0] beat_i,
  input  logic              msb_first_i,
  output logic [LANES-1:0]  beat_o
);

  logic [LANES-1:0]  slice_w [BEATS];
  logic [BEAT_W-1:0] slot_w;

  for (genvar gi = 0; gi < BEATS; gi++) begin : g_slice
    assign slice_w[gi] = word_i[gi*LANES +: LANES];
  end

  // MSB-first beat b is the same aligned slice as LSB-first beat BEATS-1-b,
  // and the slice keeps the word's own bit order, so its top lane carries
  // the highest bit.
  assign slot_w = msb_first_i ? (BEAT_W'(BEATS - 1) - beat_i) : beat_i;

  always_comb begin
    beat_o = '0;
    for (int i = 0; i < BEATS; i++) begin
      if (slot_w == BEAT_W'(i)) begin
        beat_o = slice_w[i];
      end
    end
  end

endmodule

// File: rtl/output_serializer.sv
// -----------------------------------------------------------------------------
// output_serializer
// Result drain for the N x N systolic array. An init pulse starts a frame:
// after INIT_DELAY cycles all N*N accumulator words are captured into a local
// snapshot together with the frame's bit/element order, then streamed out
// LANES bits per beat over a valid/ready handshake with first/last markers.
//   clk, rst     clock, synchronous active-high reset
//   core_out_z   [N*N*2*D_W-1:0] array results, word k at [k*W +: W]
//   init         single-cycle start pulse (ignored unless IDLE)
//   msb_first    bit order, latched at capture
//   col_major    element order, latched at capture
//   out_bus      beat stream (master side of output_serializer_if)
//   busy         high in WAIT or TX
//   overrun      one-cycle pulse after a rejected init
// -----------------------------------------------------------------------------
module output_serializer
  import output_serializer_pkg::*;
#(
  parameter int D_W        = DEF_D_W,
  parameter int N          = DEF_N,
  parameter int LANES      = DEF_LANES,
  parameter int INIT_DELAY = DEF_INIT_DELAY
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N*N*2*D_W-1:0]   core_out_z,
  input  logic                   init,
  input  logic                   msb_first,
  input  logic                   col_major,
  output_serializer_if.master    out_bus,
  output logic                   busy,
  output logic                   overrun
);

  localparam int W      = word_width(D_W);
  localparam int BEATS  = beats_per_word(D_W, LANES);
  localparam int WORDS  = N * N;
  localparam int BEAT_W = clog2_min1(BEATS);
  localparam int ELEM_W = clog2_min1(WORDS);
  localparam int DLY_W  = clog2_min1(INIT_DELAY);

  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);
  localparam logic [ELEM_W-1:0] ELEM_LAST = ELEM_W'(WORDS - 1);

  if (LANES < 1 || (W % LANES) != 0) begin : g_lanes_check
    $error("output_serializer: LANES must evenly divide 2*D_W");
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [DLY_W-1:0]  dly_q, dly_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [ELEM_W-1:0] elem_q, elem_d;
  logic              msb_q, col_q;
  logic              overrun_q, overrun_d;
  logic              capture;

  logic [W-1:0]      core_words_w [WORDS];
  logic [W-1:0]      snap_q       [WORDS];
  logic [W-1:0]      word_sel;
  logic [LANES-1:0]  beat_w;
  logic              tx_active;
  logic              xfer;
  int                sel_idx;

  for (genvar gi = 0; gi < WORDS; gi++) begin : g_unpack
    assign core_words_w[gi] = core_out_z[gi*W +: W];
  end

  assign tx_active = (state_q == ST_TX);
  assign xfer      = tx_active && out_bus.out_ready;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    dly_d     = dly_q;
    beat_d    = beat_q;
    elem_d    = elem_q;
    capture   = 1'b0;
    // Any init outside IDLE is dropped; this includes the cycle whose beat
    // closes the frame, because the FSM is still in TX when init is sampled.
    overrun_d = init && (state_q != ST_IDLE);

    unique case (state_q)
      ST_IDLE: begin
        if (init) begin
          dly_d  = '0;
          beat_d = '0;
          elem_d = '0;
          if (INIT_DELAY == 0) begin
            capture = 1'b1;
            state_d = ST_TX;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        if (int'(dly_q) == INIT_DELAY - 1) begin
          capture = 1'b1;
          state_d = ST_TX;
        end else begin
          dly_d = dly_q + 1'b1;
        end
      end

      ST_TX: begin
        if (xfer) begin
          if (beat_q == BEAT_LAST) begin
            beat_d = '0;
            if (elem_q == ELEM_LAST) begin
              elem_d  = '0;
              state_d = ST_IDLE;
            end else begin
              elem_d = elem_q + 1'b1;
            end
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      dly_q     <= '0;
      beat_q    <= '0;
      elem_q    <= '0;
      msb_q     <= 1'b0;
      col_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dly_q     <= dly_d;
      beat_q    <= beat_d;
      elem_q    <= elem_d;
      overrun_q <= overrun_d;
      if (capture) begin
        msb_q <= msb_first;
        col_q <= col_major;
      end
    end
  end

  // Snapshot contents are only observed in TX, which always follows a
  // capture, so the buffer itself needs no reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int k = 0; k < WORDS; k++) begin
        snap_q[k] <= core_words_w[k];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Beat datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    sel_idx  = map_element(int'(elem_q), N, col_q);
    word_sel = '0;
    for (int k = 0; k < WORDS; k++) begin
      if (sel_idx == k) begin
        word_sel = snap_q[k];
      end
    end
  end

  output_serializer_beat_select #(
    .W      (W),
    .LANES  (LANES),
    .BEATS  (BEATS),
    .BEAT_W (BEAT_W)
  ) u_beat_select (
    .word_i      (word_sel),
    .beat_i      (beat_q),
    .msb_first_i (msb_q),
    .beat_o      (beat_w)
  );

  // Outputs decode straight from the held counters, so a stalled beat keeps
  // its data and markers until it is accepted.
  assign out_bus.out_valid = tx_active;
  assign out_bus.out_data  = tx_active ? beat_w : '0;
  assign out_bus.out_first = tx_active && (beat_q == '0) && (elem_q == '0);
  assign out_bus.out_last  = tx_active && (beat_q == BEAT_LAST) && (elem_q == ELEM_LAST);
  assign busy              = (state_q != ST_IDLE);
  assign overrun           = overrun_q;

endmodule

// File: tb/tb_output_serializer.sv
// -----------------------------------------------------------------------------
// tb_output_serializer
// Directed bench for output_serializer. Three instances share clock, reset
// and the result bus:
//   u_ser1  LANES=1, INIT_DELAY=2   (row/LSB stream, stalls, snapshot, overrun)
//   u_ser4  LANES=4, INIT_DELAY=2   (column-major, MSB-first nibbles)
//   u_ser0  LANES=1, INIT_DELAY=0   (reset mid-frame, immediate restart)
// -----------------------------------------------------------------------------
module tb_output_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] core_z;
  logic        msb_first = 1'b0;
  logic        col_major = 1'b0;
  logic        init1 = 1'b0, init4 = 1'b0, init0 = 1'b0;
  logic        busy1, busy4, busy0;
  logic        ovr1, ovr4, ovr0;

  int checks = 0;
  int errors = 0;

  // Words k=0..3 = 0x0001, 0x8002, 0x1234, 0xFFFF. Row-major LSB-first with
  // one lane emits exactly this vector from bit 0 upward.
  logic [63:0] words_vec;
  // Column-major MSB-first nibble stream, written out by hand, first beat in
  // the top nibble: 0,0,0,1 | 1,2,3,4 | 8,0,0,2 | F,F,F,F.
  logic [63:0] exp_nib;

  output_serializer_if #(.LANES(1)) bus1 ();
  output_serializer_if #(.LANES(4)) bus4 ();
  output_serializer_if #(.LANES(1)) bus0 ();

  output_serializer #(.D_W(8), .N(2), .LANES(1), .INIT_DELAY(2)) u_ser1 (
    .clk(clk), .rst(rst), .core_out_z(core_z), .init(init1),
    .msb_first(msb_first), .col_major(col_major), .out_bus(bus1),
    .busy(busy1), .overrun(ovr1)
  );

  output_serializer #(.D_W(8), .N(2), .LANES(4), .INIT_DELAY(2)) u_ser4 (
    .clk(clk), .rst(rst), .core_out_z(core_z), .init(init4),
    .msb_first(msb_first), .col_major(col_major), .out_bus(bus4),
    .busy(busy4), .overrun(ovr4)
  );

  output_serializer #(.D_W(8), .N(2), .LANES(1), .INIT_DELAY(0)) u_ser0 (
    .clk(clk), .rst(rst), .core_out_z(core_z), .init(init0),
    .msb_first(msb_first), .col_major(col_major), .out_bus(bus0),
    .busy(busy0), .overrun(ovr0)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus1.out_valid, bus1.out_first, bus1.out_last, busy1, ovr1} !== 5'b0) begin
      errors++;
      $display("FAIL reset_u1_flags: got %b expected 00000",
               {bus1.out_valid, bus1.out_first, bus1.out_last, busy1, ovr1});
    end
    checks++;
    if ({bus4.out_valid, bus4.out_first, bus4.out_last, busy4, ovr4} !== 5'b0) begin
      errors++;
      $display("FAIL reset_u4_flags: got %b expected 00000",
               {bus4.out_valid, bus4.out_first, bus4.out_last, busy4, ovr4});
    end
    checks++;
    if ({bus0.out_valid, bus0.out_first, bus0.out_last, busy0, ovr0} !== 5'b0) begin
      errors++;
      $display("FAIL reset_u0_flags: got %b expected 00000",
               {bus0.out_valid, bus0.out_first, bus0.out_last, busy0, ovr0});
    end
    checks++;
    if ({bus1.out_data, bus4.out_data, bus0.out_data} !== 6'b0) begin
      errors++;
      $display("FAIL reset_data: got %b expected 000000",
               {bus1.out_data, bus4.out_data, bus0.out_data});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy1 !== 1'b0 || bus1.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: got busy=%b valid=%b expected 0 0", busy1, bus1.out_valid);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Runs one u_ser1 frame: toggle = out_ready pattern 1,0,0,1; zap = clear
  // core_out_z one cycle after capture; poke = init at beat 10 and again on
  // the final transfer.
  task automatic drain_u1(input string tag, input bit toggle, input bit zap, input bit poke);
    int   lat;
    int   beat;
    int   cyc;
    bit   r;
    bit   prev_stall;
    bit   poked_prev;
    bit   p10;
    logic prev_data, prev_first, prev_last;

    init1 = 1'b1;
    @(negedge clk);
    init1 = 1'b0;
    lat = 0;
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      if (bus1.out_valid === 1'b1) lat = i;
      else @(negedge clk);
    end
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL %s valid_latency: got %0d expected 3", tag, lat);
    end
    if (zap) core_z = '0;

    beat = 0; cyc = 0; prev_stall = 0; poked_prev = 0; p10 = 0;
    prev_data = 1'b0; prev_first = 1'b0; prev_last = 1'b0;
    while (beat < 64 && cyc < 400) begin
      checks++;
      if (ovr1 !== poked_prev) begin
        errors++;
        $display("FAIL %s overrun beat %0d: got %b expected %b", tag, beat, ovr1, poked_prev);
      end
      init1 = 1'b0;
      poked_prev = 0;
      checks++;
      if (bus1.out_valid !== 1'b1 || busy1 !== 1'b1) begin
        errors++;
        $display("FAIL %s valid_busy beat %0d: got %b%b expected 11", tag, beat, bus1.out_valid, busy1);
      end
      checks++;
      if (bus1.out_data[0] !== words_vec[beat]) begin
        errors++;
        $display("FAIL %s data beat %0d: got %b expected %b", tag, beat, bus1.out_data[0], words_vec[beat]);
      end
      checks++;
      if (bus1.out_first !== (beat == 0) || bus1.out_last !== (beat == 63)) begin
        errors++;
        $display("FAIL %s markers beat %0d: got first=%b last=%b expected %b %b",
                 tag, beat, bus1.out_first, bus1.out_last, beat == 0, beat == 63);
      end
      if (prev_stall) begin
        checks++;
        if ({bus1.out_data[0], bus1.out_first, bus1.out_last} !== {prev_data, prev_first, prev_last}) begin
          errors++;
          $display("FAIL %s stall_hold beat %0d: got %b expected %b", tag, beat,
                   {bus1.out_data[0], bus1.out_first, bus1.out_last}, {prev_data, prev_first, prev_last});
        end
      end
      r = toggle ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
      bus1.out_ready = r;
      if (poke && ((beat == 10 && !p10) || (beat == 63 && r))) begin
        init1 = 1'b1;
        poked_prev = 1;
        if (beat == 10) p10 = 1;
      end
      prev_stall = !r;
      prev_data  = bus1.out_data[0];
      prev_first = bus1.out_first;
      prev_last  = bus1.out_last;
      if (r) beat++;
      cyc++;
      @(negedge clk);
    end
    init1 = 1'b0;
    checks++;
    if (beat != 64) begin
      errors++;
      $display("FAIL %s transfers: got %0d expected 64", tag, beat);
    end
    checks++;
    if (ovr1 !== poked_prev) begin
      errors++;
      $display("FAIL %s overrun_last: got %b expected %b", tag, ovr1, poked_prev);
    end
    checks++;
    if (bus1.out_valid !== 1'b0 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL %s frame_end: got valid=%b busy=%b expected 0 0", tag, bus1.out_valid, busy1);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (bus1.out_valid !== 1'b0 || busy1 !== 1'b0 || ovr1 !== 1'b0) begin
      errors++;
      $display("FAIL %s stays_idle: got valid=%b busy=%b ovr=%b expected 0 0 0",
               tag, bus1.out_valid, busy1, ovr1);
    end
    bus1.out_ready = 1'b1;
    core_z = words_vec;
  endtask

  task automatic test_row_lsb();
    drain_u1("row_lsb", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_stall();
    drain_u1("stall", 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_snapshot();
    drain_u1("snapshot", 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_overrun();
    drain_u1("overrun", 1'b0, 1'b0, 1'b1);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_col_msb();
    int       lat;
    int       beat;
    int       cyc;
    logic [3:0] exp;
    msb_first = 1'b1;
    col_major = 1'b1;
    init4 = 1'b1;
    @(negedge clk);
    init4 = 1'b0;
    lat = 0;
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      if (bus4.out_valid === 1'b1) lat = i;
      else @(negedge clk);
    end
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL col_msb valid_latency: got %0d expected 3", lat);
    end
    // Order controls are latched at capture; flipping them now must not matter.
    msb_first = 1'b0;
    col_major = 1'b0;
    beat = 0; cyc = 0;
    while (beat < 16 && cyc < 40) begin
      exp = exp_nib[63 - 4*beat -: 4];
      checks++;
      if (bus4.out_valid !== 1'b1 || bus4.out_data !== exp) begin
        errors++;
        $display("FAIL col_msb nibble %0d: got valid=%b data=%h expected 1 %h",
                 beat, bus4.out_valid, bus4.out_data, exp);
      end
      checks++;
      if (bus4.out_first !== (beat == 0) || bus4.out_last !== (beat == 15)) begin
        errors++;
        $display("FAIL col_msb markers %0d: got first=%b last=%b expected %b %b",
                 beat, bus4.out_first, bus4.out_last, beat == 0, beat == 15);
      end
      beat++;
      cyc++;
      @(negedge clk);
    end
    checks++;
    if (bus4.out_valid !== 1'b0 || busy4 !== 1'b0) begin
      errors++;
      $display("FAIL col_msb frame_end: got valid=%b busy=%b expected 0 0", bus4.out_valid, busy4);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid();
    int beat;
    init0 = 1'b1;
    @(negedge clk);
    init0 = 1'b0;
    checks++;
    if (bus0.out_valid !== 1'b1 || bus0.out_first !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid zero_delay_start: got valid=%b first=%b expected 1 1",
               bus0.out_valid, bus0.out_first);
    end
    beat = 0;
    while (beat < 20) begin
      checks++;
      if (bus0.out_data[0] !== words_vec[beat]) begin
        errors++;
        $display("FAIL reset_mid data beat %0d: got %b expected %b", beat, bus0.out_data[0], words_vec[beat]);
      end
      beat++;
      @(negedge clk);
    end
    checks++;
    if (bus0.out_valid !== 1'b1 || bus0.out_data[0] !== words_vec[20]) begin
      errors++;
      $display("FAIL reset_mid beat20: got valid=%b data=%b expected 1 %b",
               bus0.out_valid, bus0.out_data[0], words_vec[20]);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({bus0.out_valid, bus0.out_first, bus0.out_last, busy0, bus0.out_data[0]} !== 5'b0) begin
      errors++;
      $display("FAIL reset_mid abort: got %b expected 00000",
               {bus0.out_valid, bus0.out_first, bus0.out_last, busy0, bus0.out_data[0]});
    end
    @(negedge clk);
    init0 = 1'b1;
    @(negedge clk);
    init0 = 1'b0;
    checks++;
    if (bus0.out_valid !== 1'b1 || bus0.out_first !== 1'b1 || bus0.out_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid restart_flags: got valid=%b first=%b last=%b expected 1 1 0",
               bus0.out_valid, bus0.out_first, bus0.out_last);
    end
    checks++;
    if (bus0.out_data[0] !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid restart_bit0: got %b expected 1", bus0.out_data[0]);
    end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    words_vec = 64'hFFFF_1234_8002_0001;
    exp_nib   = 64'h0001_1234_8002_FFFF;
    core_z    = words_vec;
    bus1.out_ready = 1'b1;
    bus4.out_ready = 1'b1;
    bus0.out_ready = 1'b1;

    test_reset();
    test_row_lsb();
    test_col_msb();
    test_stall();
    test_snapshot();
    test_overrun();
    test_reset_mid();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
